// File: rtl/fp_sqrt_pack_if.sv
// Handshake and data bundle between fp_sqrt and its pack/normalize output stage.
interface fp_sqrt_pack_if #(
    parameter int M_SIZE   = 53,
    parameter int EXP_SIZE = 11
);
    logic [M_SIZE-1:0]   in_mantisa;
    logic [EXP_SIZE-1:0] in_exp;
    logic                in_sign;
    logic                in_type;
    logic [2:0]          in_flags;
    logic                start;
    logic [63:0]         out_result;
    logic [2:0]          out_flags;
    logic                ready;
    logic                busy;

    modport master (
        output in_mantisa, in_exp, in_sign, in_type, in_flags, start,
        input  out_result, out_flags, ready, busy
    );

    modport slave (
        input  in_mantisa, in_exp, in_sign, in_type, in_flags, start,
        output out_result, out_flags, ready, busy
    );
endinterface

// File: rtl/fp_sqrt_pack.sv
// Normalize, round (single: nearest-even), rebias and pack the fp_sqrt result
// into an IEEE 754 word; one normalization shift per cycle.
module fp_sqrt_pack #(
    parameter int M_SIZE       = 53,
    parameter int EXP_SIZE     = 11,
    parameter int SGL_BIAS_ADJ = 896
) (
    input logic           clk,
    input logic           rst,
    fp_sqrt_pack_if.slave bus
);
    localparam int EW       = EXP_SIZE + 1;
    localparam int SGL_KEEP = 24;
    localparam int SGL_LOW  = M_SIZE - SGL_KEEP;

    localparam logic [EW-1:0] E_ONE  = EW'(1);
    localparam logic [EW-1:0] E_DMAX = EW'((1 << EXP_SIZE) - 1);
    localparam logic [EW-1:0] E_SMAX = EW'(255);
    localparam logic [EW:0]   E_ADJ  = (EW + 1)'(SGL_BIAS_ADJ);

    localparam logic [2:0] C_NORMAL = 3'b100;
    localparam logic [2:0] C_INF    = 3'b010;
    localparam logic [2:0] C_NAN    = 3'b001;
    localparam logic [2:0] C_ZERO   = 3'b000;

    typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;

    state_t            state, state_nxt;
    logic [M_SIZE-1:0] m, m_nxt;
    logic [EW-1:0]     e, e_nxt;
    logic              sgn, sgn_nxt;
    logic              dbl, dbl_nxt;
    logic [2:0]        cls, cls_nxt;
    logic [63:0]       res, res_nxt;
    logic [2:0]        oflags, oflags_nxt;

    logic              rnd_inc;
    logic [SGL_KEEP:0] rnd_sum;
    logic [EW:0]       e_sgl;

    function automatic logic [63:0] inf_word(input logic s, input logic d);
        return d ? {s, {EXP_SIZE{1'b1}}, {(63 - EXP_SIZE){1'b0}}}
                 : {32'h0, s, 8'hFF, 23'h0};
    endfunction

    function automatic logic [63:0] zero_word(input logic s, input logic d);
        return d ? {s, 63'h0} : {32'h0, s, 31'h0};
    endfunction

    always_comb begin
        state_nxt  = state;
        m_nxt      = m;
        e_nxt      = e;
        sgn_nxt    = sgn;
        dbl_nxt    = dbl;
        cls_nxt    = cls;
        res_nxt    = res;
        oflags_nxt = oflags;

        rnd_inc = m[SGL_LOW-1] & ((|m[SGL_LOW-2:0]) | m[SGL_LOW]);
        rnd_sum = {1'b0, m[M_SIZE-1 -: SGL_KEEP]} + {{SGL_KEEP{1'b0}}, rnd_inc};
        e_sgl   = {1'b0, e} - E_ADJ;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    m_nxt   = bus.in_mantisa;
                    e_nxt   = {1'b0, bus.in_exp};
                    sgn_nxt = bus.in_sign;
                    dbl_nxt = bus.in_type;
                    if (bus.in_flags == C_NORMAL && |bus.in_mantisa) begin
                        cls_nxt   = C_NORMAL;
                        state_nxt = NORM;
                    end else begin
                        // Specials idle through ROUND (no-op) so ready lands one
                        // cycle ahead of the fastest normalized result.
                        cls_nxt   = (bus.in_flags == C_NORMAL) ? C_ZERO : bus.in_flags;
                        state_nxt = ROUND;
                    end
                end
            end
            NORM: begin
                if (m[M_SIZE-1]) begin
                    state_nxt = ROUND;
                end else if (e <= E_ONE) begin
                    cls_nxt   = C_ZERO;
                    state_nxt = PACK;
                end else begin
                    m_nxt = m << 1;
                    e_nxt = e - E_ONE;
                end
            end
            ROUND: begin
                if (!dbl && cls == C_NORMAL) begin
                    if (rnd_sum[SGL_KEEP]) begin
                        m_nxt = {1'b1, {(M_SIZE - 1){1'b0}}};
                        e_nxt = e + E_ONE;
                    end else begin
                        m_nxt = {rnd_sum[SGL_KEEP-1:0], {SGL_LOW{1'b0}}};
                    end
                end
                state_nxt = PACK;
            end
            PACK: begin
                if (cls[0]) begin
                    res_nxt    = dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
                    oflags_nxt = C_NAN;
                end else if (cls[1]) begin
                    res_nxt    = inf_word(sgn, dbl);
                    oflags_nxt = C_INF;
                end else if (cls[2]) begin
                    if (dbl) begin
                        if (e >= E_DMAX) begin
                            res_nxt    = inf_word(sgn, 1'b1);
                            oflags_nxt = C_INF;
                        end else begin
                            res_nxt    = 64'({sgn, e[EXP_SIZE-1:0], m[M_SIZE-2:0]});
                            oflags_nxt = C_NORMAL;
                        end
                    end else if (e_sgl[EW] || e_sgl == '0) begin
                        res_nxt    = zero_word(sgn, 1'b0);
                        oflags_nxt = C_ZERO;
                    end else if (e_sgl[EW-1:0] >= E_SMAX) begin
                        res_nxt    = inf_word(sgn, 1'b0);
                        oflags_nxt = C_INF;
                    end else begin
                        res_nxt    = {32'h0, sgn, e_sgl[7:0], m[M_SIZE-2 -: 23]};
                        oflags_nxt = C_NORMAL;
                    end
                end else begin
                    res_nxt    = zero_word(sgn, dbl);
                    oflags_nxt = C_ZERO;
                end
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            m      <= '0;
            e      <= '0;
            sgn    <= 1'b0;
            dbl    <= 1'b0;
            cls    <= '0;
            res    <= '0;
            oflags <= '0;
        end else begin
            state  <= state_nxt;
            m      <= m_nxt;
            e      <= e_nxt;
            sgn    <= sgn_nxt;
            dbl    <= dbl_nxt;
            cls    <= cls_nxt;
            res    <= res_nxt;
            oflags <= oflags_nxt;
        end
    end

    assign bus.out_result = res;
    assign bus.out_flags  = oflags;
    assign bus.ready      = (state == DONE);
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_fp_sqrt_pack.sv
// Self-checking bench for fp_sqrt_pack: directed vector table, random ops against
// an arithmetic reference model, and reset/handshake corner sequences.
module tb_fp_sqrt_pack;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_sqrt_pack_if #(.M_SIZE(53), .EXP_SIZE(11)) bif ();

    fp_sqrt_pack #(.M_SIZE(53), .EXP_SIZE(11), .SGL_BIAS_ADJ(896)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [52:0] mant;
        logic [10:0] exp;
        logic        sgn;
        logic        dbl;
        logic [2:0]  flags;
        logic [63:0] want_res;
        logic [2:0]  want_flags;
        int          want_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [52:0] mant, input logic [10:0] exp, input logic sgn,
                         input logic dbl, input logic [2:0] flags);
        bif.in_mantisa = mant;
        bif.in_exp     = exp;
        bif.in_sign    = sgn;
        bif.in_type    = dbl;
        bif.in_flags   = flags;
    endtask

    // Latency = number of rising edges from the one that samples start up to
    // and including the edge after which ready is seen high.
    task automatic run_op(input logic [52:0] mant, input logic [10:0] exp, input logic sgn,
                          input logic dbl, input logic [2:0] flags,
                          output logic [63:0] res, output logic [2:0] fl, output int lat);
        @(negedge clk);
        drive(mant, exp, sgn, dbl, flags);
        bif.start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bif.start = 1'b0;
        while (!bif.ready && lat < 2300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bif.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: no ready after %0d edges", lat);
            lat = -1;
        end
        res = bif.out_result;
        fl  = bif.out_flags;
    endtask

    // Reference: value-level normalize / round-half-even / rebias.
    function automatic void model(input logic [52:0] mant, input int exp, input logic sgn,
                                  input logic dbl, input logic [2:0] flags,
                                  output logic [63:0] res, output logic [2:0] fl, output int lat);
        int          lz;
        int          e;
        int          es;
        logic [63:0] m;
        logic [63:0] frac;
        logic [63:0] rem;
        logic [63:0] half;
        logic [63:0] inf_w;
        logic [63:0] zero_w;
        inf_w  = dbl ? {sgn, 11'h7FF, 52'h0} : {32'h0, sgn, 8'hFF, 23'h0};
        zero_w = dbl ? {sgn, 63'h0} : {32'h0, sgn, 31'h0};
        if (flags != 3'b100 || mant == '0) begin
            lat = 3;
            if (flags[0]) begin
                res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
                fl  = 3'b001;
            end else if (flags[1]) begin
                res = inf_w;
                fl  = 3'b010;
            end else begin
                res = zero_w;
                fl  = 3'b000;
            end
            return;
        end
        lz = 0;
        for (int i = 52; i >= 0; i--) begin
            if (mant[i]) begin
                lz = 52 - i;
                break;
            end
        end
        if (lz > 0 && exp <= lz) begin
            lat = ((exp > 1) ? exp : 1) + 2;
            res = zero_w;
            fl  = 3'b000;
            return;
        end
        lat = 4 + lz;
        m   = 64'(mant) << lz;
        e   = exp - lz;
        if (dbl) begin
            if (e >= 2047) begin
                res = inf_w;
                fl  = 3'b010;
            end else begin
                res = {sgn, 11'(e), m[51:0]};
                fl  = 3'b100;
            end
            return;
        end
        half = 64'd1 << 28;
        frac = m >> 29;
        rem  = m % (64'd1 << 29);
        if (rem > half || (rem == half && frac[0])) frac = frac + 64'd1;
        if (frac == (64'd1 << 24)) begin
            frac = 64'd1 << 23;
            e    = e + 1;
        end
        es = e - 896;
        if (es <= 0) begin
            res = zero_w;
            fl  = 3'b000;
        end else if (es >= 255) begin
            res = inf_w;
            fl  = 3'b010;
        end else begin
            res = {32'h0, sgn, 8'(es), frac[22:0]};
            fl  = 3'b100;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[16];
        logic [63:0] res;
        logic [63:0] want_res;
        logic [63:0] r64;
        logic [2:0]  fl;
        logic [2:0]  want_fl;
        logic [52:0] mant;
        logic [10:0] exp;
        logic [2:0]  flags;
        logic        sgn;
        logic        dbl;
        int          lat;
        int          want_lat;
        int          pulses;

        vecs[0]  = '{53'h1 << 52, 11'd1023, 1'b0, 1'b1, 3'b100, 64'h3FF0_0000_0000_0000, 3'b100, 4};
        vecs[1]  = '{53'h1 << 50, 11'd1023, 1'b0, 1'b1, 3'b100, 64'h3FD0_0000_0000_0000, 3'b100, 6};
        vecs[2]  = '{53'h1F_FFFF_FFFF_FFFF, 11'd1023, 1'b0, 1'b0, 3'b100, 64'h0000_0000_4000_0000, 3'b100, 4};
        vecs[3]  = '{(53'h1 << 52) | (53'h1 << 28), 11'd1023, 1'b0, 1'b0, 3'b100, 64'h0000_0000_3F80_0000, 3'b100, 4};
        vecs[4]  = '{(53'h1 << 52) | (53'h1 << 29) | (53'h1 << 28), 11'd1023, 1'b0, 1'b0, 3'b100,
                     64'h0000_0000_3F80_0002, 3'b100, 4};
        vecs[5]  = '{53'h0, 11'd0, 1'b1, 1'b1, 3'b010, 64'hFFF0_0000_0000_0000, 3'b010, 3};
        vecs[6]  = '{53'h0, 11'd0, 1'b1, 1'b0, 3'b001, 64'h0000_0000_7FC0_0000, 3'b001, 3};
        vecs[7]  = '{53'h1 << 52, 11'd800, 1'b0, 1'b0, 3'b100, 64'h0, 3'b000, 4};
        vecs[8]  = '{53'h0, 11'd0, 1'b1, 1'b1, 3'b000, 64'h8000_0000_0000_0000, 3'b000, 3};
        vecs[9]  = '{53'h0, 11'd1023, 1'b0, 1'b1, 3'b100, 64'h0, 3'b000, 3};
        vecs[10] = '{53'h1 << 52, 11'd2047, 1'b0, 1'b1, 3'b100, 64'h7FF0_0000_0000_0000, 3'b010, 4};
        vecs[11] = '{53'h1 << 52, 11'd1151, 1'b1, 1'b0, 3'b100, 64'h0000_0000_FF80_0000, 3'b010, 4};
        vecs[12] = '{53'h1 << 45, 11'd5, 1'b0, 1'b1, 3'b100, 64'h0, 3'b000, 7};
        vecs[13] = '{53'h1 << 52, 11'd897, 1'b0, 1'b0, 3'b100, 64'h0000_0000_0080_0000, 3'b100, 4};
        vecs[14] = '{53'h1F_FFFF_FFFF_FFFF, 11'd1023, 1'b0, 1'b1, 3'b100, 64'h3FFF_FFFF_FFFF_FFFF, 3'b100, 4};
        vecs[15] = '{53'h0, 11'd0, 1'b0, 1'b1, 3'b001, 64'h7FF8_0000_0000_0000, 3'b001, 3};

        rst       = 1'b0;
        bif.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0, '0);
        #12;
        check("reset_result", bif.out_result, 64'h0);
        check("reset_flags", 64'(bif.out_flags), 64'h0);
        check("reset_ready", 64'(bif.ready), 64'h0);
        check("reset_busy", 64'(bif.busy), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].mant, vecs[i].exp, vecs[i].sgn, vecs[i].dbl, vecs[i].flags, res, fl, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].want_res);
            check($sformatf("vec%0d_flags", i), 64'(fl), 64'(vecs[i].want_flags));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].want_lat));
        end

        for (int n = 0; n < 40; n++) begin
            r64   = {$urandom(), $urandom()};
            mant  = r64[52:0] >> $urandom_range(0, 24);
            exp   = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047))
                                                : 11'($urandom_range(850, 1250));
            flags = ($urandom_range(0, 4) == 0) ? 3'($urandom()) : 3'b100;
            sgn   = 1'($urandom());
            dbl   = 1'($urandom());
            model(mant, int'(exp), sgn, dbl, flags, want_res, want_fl, want_lat);
            run_op(mant, exp, sgn, dbl, flags, res, fl, lat);
            check($sformatf("rand%0d_result", n), res, want_res);
            check($sformatf("rand%0d_flags", n), 64'(fl), 64'(want_fl));
            check($sformatf("rand%0d_latency", n), 64'(lat), 64'(want_lat));
        end

        // Reset in the middle of a long normalization.
        run_op(vecs[0].mant, vecs[0].exp, 1'b0, 1'b1, 3'b100, res, fl, lat);
        @(negedge clk);
        drive(53'h1 << 10, 11'd1023, 1'b0, 1'b1, 3'b100);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (5) @(negedge clk);
        check("norm_busy_before_reset", 64'(bif.busy), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_busy", 64'(bif.busy), 64'h0);
        check("midreset_ready", 64'(bif.ready), 64'h0);
        check("midreset_result", bif.out_result, 64'h0);
        check("midreset_flags", 64'(bif.out_flags), 64'h0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (bif.ready) pulses++;
        end
        check("midreset_no_ready", 64'(pulses), 64'h0);
        run_op(vecs[0].mant, vecs[0].exp, 1'b0, 1'b1, 3'b100, res, fl, lat);
        check("after_reset_result", res, 64'h3FF0_0000_0000_0000);
        check("after_reset_latency", 64'(lat), 64'd4);

        // A second start while busy is dropped.
        model(53'h1 << 40, 1023, 1'b0, 1'b1, 3'b100, want_res, want_fl, want_lat);
        @(negedge clk);
        drive(53'h1 << 40, 11'd1023, 1'b0, 1'b1, 3'b100);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        drive(53'h0, 11'd0, 1'b1, 1'b1, 3'b010);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bif.ready) begin
                pulses++;
                res = bif.out_result;
            end
        end
        check("busy_start_pulses", 64'(pulses), 64'h1);
        check("busy_start_result", res, want_res);

        // Start raised during the DONE cycle is ignored, then taken in IDLE.
        run_op(vecs[3].mant, vecs[3].exp, 1'b0, 1'b0, 3'b100, res, fl, lat);
        drive(53'h1 << 52, 11'd1024, 1'b0, 1'b1, 3'b100);
        bif.start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", 64'(bif.busy), 64'h0);
        @(negedge clk);
        bif.start = 1'b0;
        check("idle_start_taken", 64'(bif.busy), 64'h1);
        lat = 1;
        while (!bif.ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("idle_start_latency", 64'(lat), 64'd4);
        check("idle_start_result", bif.out_result, 64'h4000_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
